serializer_rr_arbiter: RTL

//  Shares one serializer between N_REQ parallel-word requesters. Round-robin arbitration.

---
 rtl/serializer_rr_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/serializer_rr_arbiter.sv
// Round-robin arbiter sharing one serializer between N_REQ word requesters.
// Drops words with mod 1 or 2; waits for busy to rise and fall between transfers.
module serializer_rr_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned DATA_BUS_WIDTH = 16,
  parameter int unsigned DATA_MOD_WIDTH = 4,
  parameter int unsigned START_TIMEOUT  = 4
) (
  input  logic                              clk_i,
  input  logic                              arst_n_i,
  input  logic [N_REQ*DATA_BUS_WIDTH-1:0]   req_data_i,
  input  logic [N_REQ*DATA_MOD_WIDTH-1:0]   req_mod_i,
  input  logic [N_REQ-1:0]                  req_val_i,
  output logic [N_REQ-1:0]                  req_ready_o,
  output logic [DATA_BUS_WIDTH-1:0]         ser_data_o,
  output logic [DATA_MOD_WIDTH-1:0]         ser_mod_o,
  output logic                              ser_val_o,
  input  logic                              ser_busy_i,
  output logic [$clog2(N_REQ)-1:0]          grant_id_o,
  output logic                              drop_o,
  output logic                              timeout_o
);

  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(START_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitDone} state_e;

  state_e                    state_q, state_d;
  logic [IdW-1:0]            ptr_q, ptr_d;
  logic [IdW-1:0]            gid_q, gid_d;
  logic [DATA_BUS_WIDTH-1:0] data_q, data_d;
  logic [DATA_MOD_WIDTH-1:0] mod_q, mod_d;
  logic                      val_q, val_d;
  logic                      drop_q, drop_d;
  logic                      tout_q, tout_d;
  logic [CntW-1:0]           cnt_q, cnt_d;

  logic                      found;
  logic [IdW-1:0]            win;
  logic [IdW:0]              idx_sum;
  logic [IdW-1:0]            idx;
  logic [DATA_BUS_WIDTH-1:0] sel_data;
  logic [DATA_MOD_WIDTH-1:0] sel_mod;
  logic                      consume;
  logic                      is_drop;

  // Search ptr, ptr+1, ... with explicit wrap so non-power-of-2 N_REQ works.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    idx_sum = '0;
    idx     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx_sum = {1'b0, ptr_q} + (IdW + 1)'(i);
      if (idx_sum >= (IdW + 1)'(N_REQ)) begin
        idx_sum = idx_sum - (IdW + 1)'(N_REQ);
      end
      idx = idx_sum[IdW-1:0];
      if (!found && req_val_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign sel_data = req_data_i[win*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
  assign sel_mod  = req_mod_i[win*DATA_MOD_WIDTH +: DATA_MOD_WIDTH];
  assign consume  = (state_q == StIdle) && found && !ser_busy_i;
  assign is_drop  = (sel_mod == DATA_MOD_WIDTH'(1)) || (sel_mod == DATA_MOD_WIDTH'(2));

  // Ready is combinational; gate with reset so it reads 0 while reset is held.
  always_comb begin
    req_ready_o = '0;
    if (consume && arst_n_i) begin
      req_ready_o[win] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    data_d  = data_q;
    mod_d   = mod_q;
    val_d   = 1'b0;
    drop_d  = 1'b0;
    tout_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (consume) begin
          if (win == IdW'(N_REQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = win + 1'b1;
          end
          if (is_drop) begin
            drop_d = 1'b1;
          end else begin
            data_d  = sel_data;
            mod_d   = sel_mod;
            gid_d   = win;
            val_d   = 1'b1;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (ser_busy_i) begin
          state_d = StWaitDone;
        end else if (cnt_q == CntW'(START_TIMEOUT - 1)) begin
          tout_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!ser_busy_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gid_q   <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
      drop_q  <= 1'b0;
      tout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
      drop_q  <= drop_d;
      tout_q  <= tout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ser_data_o = data_q;
  assign ser_mod_o  = mod_q;
  assign ser_val_o  = val_q;
  assign grant_id_o = gid_q;
  assign drop_o     = drop_q;
  assign timeout_o  = tout_q;

endmodule
